ifetch_unit: RTL and testbench

Instruction-fetch bus initiator for the multi-cycle MIPS32 core. Owns the program counter, drives the instruction ROM's chip-enable, read-enable and address lines, waits a fixed number of wait states, and latches the returned word into the instruction register. It performs one fetch per request from the control FSM. It accepts PC redirects from branch/jump logic, including redirects that arrive while a fetch is in flight.

---
 rtl/ifetch_unit_if.sv | 35 +++
 rtl/ifetch_unit.sv | 128 ++++++++++++
 tb/tb_ifetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Interfaces for the instruction-fetch unit.
//   ifetch_rom_if  : ROM read bus. master = fetch unit (initiator), slave = ROM.
//     rom_nce (chip enable, active-low), rom_re (read enable), rom_addr[8:0],
//     rom_data[31:0] (valid only while rom_nce=0 and rom_re=1)
//   ifetch_ctrl_if : control/datapath side. master = control FSM / PC logic,
//     slave = fetch unit.
//     fetch_req, pc_wr, pc_next in; ir, pc, pc_plus4, fetch_done, busy, addr_err out
interface ifetch_rom_if;
  logic        rom_nce;
  logic        rom_re;
  logic [8:0]  rom_addr;
  logic [31:0] rom_data;

  modport master (output rom_nce, output rom_re, output rom_addr, input rom_data);
  modport slave  (input rom_nce, input rom_re, input rom_addr, output rom_data);
endinterface

interface ifetch_ctrl_if;
  logic        fetch_req;
  logic        pc_wr;
  logic [31:0] pc_next;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_done;
  logic        busy;
  logic        addr_err;

  modport master (output fetch_req, output pc_wr, output pc_next,
                  input ir, input pc, input pc_plus4,
                  input fetch_done, input busy, input addr_err);
  modport slave  (input fetch_req, input pc_wr, input pc_next,
                  output ir, output pc, output pc_plus4,
                  output fetch_done, output busy, output addr_err);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch bus initiator: owns the PC, runs one fixed-latency ROM read
// per request, latches the word into IR and advances or redirects the PC.
// Ports:
//   clk      : system clock, rising edge
//   nrst     : synchronous active-low reset
//   ctrl_if  : fetch_req / pc_wr / pc_next in; ir / pc / pc_plus4 /
//              fetch_done / busy / addr_err out (all registered except pc_plus4)
//   rom_if   : rom_nce / rom_re / rom_addr out (registered), rom_data in
module ifetch_unit #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         nrst,
  ifetch_ctrl_if.slave ctrl_if,
  ifetch_rom_if.master rom_if
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     r_ir;
  logic [XLEN-1:0]     r_pend_pc;
  logic                r_pend;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rom_nce;
  logic                r_rom_re;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic                r_fetch_done;
  logic                r_busy;
  logic                r_addr_err;

  logic                w_pc_bad;
  logic [XLEN-1:0]     w_pc_plus4;

  // PC must be word aligned and inside the 512-byte ROM window.
  assign w_pc_bad   = (r_pc[1:0] != 2'b00) || (r_pc[XLEN-1:ADDR_W] != '0);
  assign w_pc_plus4 = r_pc + XLEN'(4);

  // Fetch FSM with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_pend_pc    <= '0;
      r_pend       <= 1'b0;
      r_cnt        <= '0;
      r_rom_nce    <= 1'b1;
      r_rom_re     <= 1'b0;
      r_rom_addr   <= '0;
      r_fetch_done <= 1'b0;
      r_busy       <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_fetch_done <= 1'b0;
      r_addr_err   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (ctrl_if.pc_wr) r_pc <= ctrl_if.pc_next;
          if (ctrl_if.fetch_req && !w_pc_bad) begin
            r_state    <= ST_REQ;
            r_rom_nce  <= 1'b0;
            r_rom_re   <= 1'b1;
            r_rom_addr <= r_pc[ADDR_W-1:0];
            r_cnt      <= CNT_W'(WAIT_STATES);
            r_busy     <= 1'b1;
            // A same-cycle redirect must survive the pc+4 at completion.
            if (ctrl_if.pc_wr) begin
              r_pend    <= 1'b1;
              r_pend_pc <= ctrl_if.pc_next;
            end
          end else begin
            r_state <= ST_IDLE;
            if (ctrl_if.fetch_req) r_addr_err <= 1'b1;
          end
        end
        ST_REQ: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (ctrl_if.pc_wr) begin
              r_pend    <= 1'b1;
              r_pend_pc <= ctrl_if.pc_next;
            end
          end else begin
            r_ir <= rom_if.rom_data;
            // Redirect on the completing edge beats any older pending target.
            if (ctrl_if.pc_wr)  r_pc <= ctrl_if.pc_next;
            else if (r_pend)    r_pc <= r_pend_pc;
            else                r_pc <= w_pc_plus4;
            r_pend       <= 1'b0;
            r_rom_nce    <= 1'b1;
            r_rom_re     <= 1'b0;
            r_busy       <= 1'b0;
            r_fetch_done <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_rom_nce <= 1'b1;
          r_rom_re  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign rom_if.rom_nce     = r_rom_nce;
  assign rom_if.rom_re      = r_rom_re;
  assign rom_if.rom_addr    = r_rom_addr;
  assign ctrl_if.ir         = r_ir;
  assign ctrl_if.pc         = r_pc;
  assign ctrl_if.pc_plus4   = w_pc_plus4;
  assign ctrl_if.fetch_done = r_fetch_done;
  assign ctrl_if.busy       = r_busy;
  assign ctrl_if.addr_err   = r_addr_err;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: dut1 uses WAIT_STATES=1, dut3 uses WAIT_STATES=3.
// ROM word at byte address a is 32'hC0DE_0000 + a/4, except word 0 = 32'h20010008.
module tb_ifetch_unit;

  logic clk;
  logic nrst1;
  logic nrst3;
  int   checks;
  int   failures;
  logic [31:0] rom_mem [0:127];

  ifetch_ctrl_if ctl1 ();
  ifetch_rom_if  rom1 ();
  ifetch_ctrl_if ctl3 ();
  ifetch_rom_if  rom3 ();

  ifetch_unit #(.WAIT_STATES(1), .RESET_PC(32'h0)) dut1 (
    .clk(clk), .nrst(nrst1), .ctrl_if(ctl1), .rom_if(rom1));
  ifetch_unit #(.WAIT_STATES(3), .RESET_PC(32'h0)) dut3 (
    .clk(clk), .nrst(nrst3), .ctrl_if(ctl3), .rom_if(rom3));

  // ROM model: drives data only while selected, floats otherwise.
  assign rom1.rom_data = (!rom1.rom_nce && rom1.rom_re) ? rom_mem[rom1.rom_addr[8:2]] : 32'hzzzz_zzzz;
  assign rom3.rom_data = (!rom3.rom_nce && rom3.rom_re) ? rom_mem[rom3.rom_addr[8:2]] : 32'hzzzz_zzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst1 = 1'b0;
    tick();
    tick();
    checks++; if (ctl1.pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", ctl1.pc, 32'h0); end
    checks++; if (ctl1.ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=%h", ctl1.ir, 32'h0); end
    checks++; if (rom1.rom_nce !== 1'b1) begin failures++; $display("FAIL reset_nce got=%b exp=1", rom1.rom_nce); end
    checks++; if (rom1.rom_re !== 1'b0) begin failures++; $display("FAIL reset_re got=%b exp=0", rom1.rom_re); end
    checks++; if (rom1.rom_addr !== 9'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", rom1.rom_addr); end
    checks++; if (ctl1.fetch_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", ctl1.fetch_done); end
    checks++; if (ctl1.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ctl1.busy); end
    checks++; if (ctl1.addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err got=%b exp=0", ctl1.addr_err); end
    checks++; if (ctl1.pc_plus4 !== 32'h4) begin failures++; $display("FAIL reset_pc_plus4 got=%h exp=%h", ctl1.pc_plus4, 32'h4); end
    nrst1 = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    ctl1.fetch_req = 1'b1;
    tick();
    ctl1.fetch_req = 1'b0;
    checks++; if (rom1.rom_nce !== 1'b0 || rom1.rom_re !== 1'b1) begin failures++; $display("FAIL single_t1_bus got nce=%b re=%b exp nce=0 re=1", rom1.rom_nce, rom1.rom_re); end
    checks++; if (rom1.rom_addr !== 9'h000) begin failures++; $display("FAIL single_t1_addr got=%h exp=000", rom1.rom_addr); end
    checks++; if (ctl1.busy !== 1'b1) begin failures++; $display("FAIL single_t1_busy got=%b exp=1", ctl1.busy); end
    tick();
    checks++; if (rom1.rom_nce !== 1'b0 || ctl1.fetch_done !== 1'b0) begin failures++; $display("FAIL single_t2 got nce=%b done=%b exp nce=0 done=0", rom1.rom_nce, ctl1.fetch_done); end
    tick();
    checks++; if (ctl1.fetch_done !== 1'b1) begin failures++; $display("FAIL single_t3_done got=%b exp=1", ctl1.fetch_done); end
    checks++; if (ctl1.ir !== 32'h20010008) begin failures++; $display("FAIL single_ir got=%h exp=%h", ctl1.ir, 32'h20010008); end
    checks++; if (ctl1.pc !== 32'h4) begin failures++; $display("FAIL single_pc got=%h exp=%h", ctl1.pc, 32'h4); end
    checks++; if (rom1.rom_nce !== 1'b1 || ctl1.busy !== 1'b0) begin failures++; $display("FAIL single_t3_release got nce=%b busy=%b exp nce=1 busy=0", rom1.rom_nce, ctl1.busy); end
    tick();
    checks++; if (ctl1.fetch_done !== 1'b0) begin failures++; $display("FAIL single_t4_done got=%b exp=0", ctl1.fetch_done); end
  endtask

  task automatic test_redirect_idle();
    ctl1.pc_wr = 1'b1; ctl1.pc_next = 32'h4C;
    tick();
    ctl1.pc_wr = 1'b0;
    checks++; if (ctl1.pc !== 32'h4C) begin failures++; $display("FAIL redir_idle_pc got=%h exp=%h", ctl1.pc, 32'h4C); end
    checks++; if (ctl1.pc_plus4 !== 32'h50) begin failures++; $display("FAIL redir_idle_pc_plus4 got=%h exp=%h", ctl1.pc_plus4, 32'h50); end
    ctl1.fetch_req = 1'b1;
    tick();
    ctl1.fetch_req = 1'b0;
    checks++; if (rom1.rom_addr !== 9'h04C) begin failures++; $display("FAIL redir_idle_addr got=%h exp=04c", rom1.rom_addr); end
    tick();
    tick();
    checks++; if (ctl1.fetch_done !== 1'b1 || ctl1.ir !== 32'hC0DE0013) begin failures++; $display("FAIL redir_idle_ir got done=%b ir=%h exp done=1 ir=c0de0013", ctl1.fetch_done, ctl1.ir); end
    checks++; if (ctl1.pc !== 32'h50) begin failures++; $display("FAIL redir_idle_pc_after got=%h exp=%h", ctl1.pc, 32'h50); end
    tick();
  endtask

  task automatic test_redirect_inflight();
    ctl1.pc_wr = 1'b1; ctl1.pc_next = 32'h28;
    tick();
    ctl1.pc_wr = 1'b0;
    ctl1.fetch_req = 1'b1;
    tick();
    ctl1.fetch_req = 1'b0;
    ctl1.pc_wr = 1'b1; ctl1.pc_next = 32'h34;
    tick();
    ctl1.pc_wr = 1'b0;
    checks++; if (ctl1.pc !== 32'h28) begin failures++; $display("FAIL inflight_pc_held got=%h exp=%h", ctl1.pc, 32'h28); end
    checks++; if (rom1.rom_addr !== 9'h028) begin failures++; $display("FAIL inflight_addr got=%h exp=028", rom1.rom_addr); end
    tick();
    checks++; if (ctl1.ir !== 32'hC0DE000A) begin failures++; $display("FAIL inflight_ir got=%h exp=c0de000a", ctl1.ir); end
    checks++; if (ctl1.pc !== 32'h34) begin failures++; $display("FAIL inflight_pc got=%h exp=%h", ctl1.pc, 32'h34); end
    tick();
    ctl1.fetch_req = 1'b1;
    tick();
    ctl1.fetch_req = 1'b0;
    checks++; if (rom1.rom_addr !== 9'h034) begin failures++; $display("FAIL inflight_next_addr got=%h exp=034", rom1.rom_addr); end
    tick();
    tick();
    checks++; if (ctl1.ir !== 32'hC0DE000D || ctl1.pc !== 32'h38) begin failures++; $display("FAIL inflight_next got ir=%h pc=%h exp ir=c0de000d pc=38", ctl1.ir, ctl1.pc); end
    tick();
  endtask

  // Two redirects in one REQ, the second on the completing edge: last one wins.
  task automatic test_last_wins();
    ctl1.fetch_req = 1'b1;
    tick();
    ctl1.fetch_req = 1'b0;
    ctl1.pc_wr = 1'b1; ctl1.pc_next = 32'h40;
    tick();
    ctl1.pc_next = 32'h44;
    tick();
    ctl1.pc_wr = 1'b0;
    checks++; if (ctl1.ir !== 32'hC0DE000E) begin failures++; $display("FAIL last_wins_ir got=%h exp=c0de000e", ctl1.ir); end
    checks++; if (ctl1.pc !== 32'h44) begin failures++; $display("FAIL last_wins_pc got=%h exp=%h", ctl1.pc, 32'h44); end
    tick();
  endtask

  task automatic test_same_cycle_redirect();
    ctl1.pc_wr = 1'b1; ctl1.pc_next = 32'h10;
    tick();
    ctl1.pc_next = 32'h60;
    ctl1.fetch_req = 1'b1;
    tick();
    ctl1.pc_wr = 1'b0;
    ctl1.fetch_req = 1'b0;
    checks++; if (rom1.rom_addr !== 9'h010) begin failures++; $display("FAIL same_cycle_addr got=%h exp=010", rom1.rom_addr); end
    tick();
    tick();
    checks++; if (ctl1.ir !== 32'hC0DE0004 || ctl1.pc !== 32'h60) begin failures++; $display("FAIL same_cycle got ir=%h pc=%h exp ir=c0de0004 pc=60", ctl1.ir, ctl1.pc); end
    tick();
  endtask

  task automatic test_bad_pc();
    logic [31:0] bad [2];
    bad[0] = 32'h06;
    bad[1] = 32'h200;
    for (int i = 0; i < 2; i++) begin
      ctl1.pc_wr = 1'b1; ctl1.pc_next = bad[i];
      tick();
      ctl1.pc_wr = 1'b0;
      ctl1.fetch_req = 1'b1;
      tick();
      ctl1.fetch_req = 1'b0;
      checks++; if (ctl1.addr_err !== 1'b1) begin failures++; $display("FAIL bad_pc%0d_err got=%b exp=1", i, ctl1.addr_err); end
      checks++; if (rom1.rom_nce !== 1'b1 || ctl1.busy !== 1'b0) begin failures++; $display("FAIL bad_pc%0d_bus got nce=%b busy=%b exp nce=1 busy=0", i, rom1.rom_nce, ctl1.busy); end
      tick();
      checks++; if (ctl1.addr_err !== 1'b0 || rom1.rom_nce !== 1'b1) begin failures++; $display("FAIL bad_pc%0d_after got err=%b nce=%b exp err=0 nce=1", i, ctl1.addr_err, rom1.rom_nce); end
      checks++; if (ctl1.ir !== 32'hC0DE0004 || ctl1.pc !== bad[i]) begin failures++; $display("FAIL bad_pc%0d_state got ir=%h pc=%h exp ir=c0de0004 pc=%h", i, ctl1.ir, ctl1.pc, bad[i]); end
    end
  endtask

  task automatic test_wrap();
    ctl1.pc_wr = 1'b1; ctl1.pc_next = 32'hFFFF_FFFC;
    tick();
    ctl1.pc_wr = 1'b0;
    checks++; if (ctl1.pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc_plus4 got=%h exp=0", ctl1.pc_plus4); end
  endtask

  task automatic test_reset_mid_req();
    nrst3 = 1'b0;
    tick();
    tick();
    nrst3 = 1'b1;
    ctl3.fetch_req = 1'b1;
    tick();
    ctl3.fetch_req = 1'b0;
    checks++; if (rom3.rom_nce !== 1'b0 || ctl3.busy !== 1'b1) begin failures++; $display("FAIL midreq_start got nce=%b busy=%b exp nce=0 busy=1", rom3.rom_nce, ctl3.busy); end
    tick();
    nrst3 = 1'b0;
    tick();
    nrst3 = 1'b1;
    checks++; if (rom3.rom_nce !== 1'b1 || rom3.rom_re !== 1'b0) begin failures++; $display("FAIL midreq_release got nce=%b re=%b exp nce=1 re=0", rom3.rom_nce, rom3.rom_re); end
    checks++; if (ctl3.busy !== 1'b0 || ctl3.pc !== 32'h0 || ctl3.ir !== 32'h0) begin failures++; $display("FAIL midreq_state got busy=%b pc=%h ir=%h exp busy=0 pc=0 ir=0", ctl3.busy, ctl3.pc, ctl3.ir); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (ctl3.fetch_done !== 1'b0 || rom3.rom_nce !== 1'b1) begin failures++; $display("FAIL midreq_quiet%0d got done=%b nce=%b exp done=0 nce=1", k, ctl3.fetch_done, rom3.rom_nce); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_ir [4];
    exp_ir[0] = 32'h0;
    exp_ir[1] = 32'h20010008;
    exp_ir[2] = 32'hC0DE0001;
    exp_ir[3] = 32'hC0DE0002;
    ctl3.fetch_req = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 15) ctl3.fetch_req = 1'b0;
      checks++; if (ctl3.fetch_done !== (k % 5 == 0)) begin failures++; $display("FAIL b2b_done_c%0d got=%b exp=%b", k, ctl3.fetch_done, (k % 5 == 0)); end
      checks++; if (ctl3.pc !== 32'(4 * (k / 5))) begin failures++; $display("FAIL b2b_pc_c%0d got=%h exp=%h", k, ctl3.pc, 32'(4 * (k / 5))); end
      checks++; if (rom3.rom_nce !== (k % 5 == 0)) begin failures++; $display("FAIL b2b_nce_c%0d got=%b exp=%b", k, rom3.rom_nce, (k % 5 == 0)); end
      if (k % 5 == 0) begin
        checks++; if (ctl3.ir !== exp_ir[k / 5]) begin failures++; $display("FAIL b2b_ir_c%0d got=%h exp=%h", k, ctl3.ir, exp_ir[k / 5]); end
      end else begin
        checks++; if (rom3.rom_addr !== 9'(4 * (k / 5))) begin failures++; $display("FAIL b2b_addr_c%0d got=%h exp=%h", k, rom3.rom_addr, 9'(4 * (k / 5))); end
      end
    end
    tick();
    checks++; if (ctl3.busy !== 1'b0 || rom3.rom_nce !== 1'b1 || ctl3.pc !== 32'hC) begin failures++; $display("FAIL b2b_stop got busy=%b nce=%b pc=%h exp busy=0 nce=1 pc=c", ctl3.busy, rom3.rom_nce, ctl3.pc); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 128; i++) rom_mem[i] = 32'hC0DE_0000 + 32'(i);
    rom_mem[0] = 32'h20010008;
    nrst1 = 1'b0;
    nrst3 = 1'b0;
    ctl1.fetch_req = 1'b0; ctl1.pc_wr = 1'b0; ctl1.pc_next = 32'h0;
    ctl3.fetch_req = 1'b0; ctl3.pc_wr = 1'b0; ctl3.pc_next = 32'h0;

    test_reset();
    test_single_fetch();
    test_redirect_idle();
    test_redirect_inflight();
    test_last_wins();
    test_same_cycle_redirect();
    test_bad_pc();
    test_wrap();
    test_reset_mid_req();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
